fetch_unit: RTL

Instruction-fetch stage directly upstream of the decode stage. It drives sequential PCs to instruction memory over a req/ack handshake and buffers returned words in a small prefetch FIFO. It presents ir/pc_out to decode, holds them while decode asserts stall_if, and flushes on a taken-branch redirect. When the FIFO is empty it inserts NOP bubbles.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding decode.
// Issues sequential word-aligned PCs to instruction memory over a
// single-outstanding req/ack handshake. Returned words go into a
// DEPTH-entry prefetch FIFO. The FIFO head is popped into ir/pc_out
// each unstalled cycle; NOP bubbles are inserted when the FIFO is empty.
// Ports:
//   clock, reset              stage clock, async active-high reset
//   stall_if                  decode hold: freeze ir/pc_out/ir_valid, no pop
//   redirect, redirect_pc     taken branch: flush FIFO, refetch from redirect_pc
//   imem_req/addr/ack/data    instruction memory handshake
//   ir, pc_out, ir_valid      registered instruction, its PC, and a valid flag
module fetch_unit #(
  parameter logic [0:31] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter logic [0:31] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_data,
  output logic [0:31] ir,
  output logic [0:31] pc_out,
  output logic        ir_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } state_t;

  state_t        state, state_next;
  logic [0:31]   fetch_pc, fetch_pc_next;
  logic          req_next;
  logic          push, pop, flush;
  logic [CW-1:0] count, count_pop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [0:31]   fifo_pc [DEPTH];
  logic [0:31]   fifo_ir [DEPTH];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, handshake control and FIFO push/pop decisions
  always_comb begin
    state_next    = state;
    req_next      = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;
    fetch_pc_next = fetch_pc;
    pop           = !redirect && !stall_if && (count != '0);
    count_pop     = count - CW'(pop);

    if (redirect) begin
      flush         = 1'b1;
      fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
      unique case (state)
        // Without an ack the in-flight response is still owed and must be dropped
        ST_WAIT: state_next = imem_ack ? ST_IDLE : ST_DROP;
        ST_DROP: state_next = imem_ack ? ST_IDLE : ST_DROP;
        default: state_next = ST_IDLE;
      endcase
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (count_pop < CW'(DEPTH)) begin
            state_next = ST_WAIT;
            req_next   = 1'b1;
          end
        end
        ST_WAIT: begin
          req_next = 1'b1;
          if (imem_ack) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc + 32'd4;
            // Next request needs a free slot after this cycle's push and pop
            if (count_pop >= CW'(DEPTH - 1)) begin
              state_next = ST_IDLE;
              req_next   = 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (imem_ack) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Fetch PC, memory request outputs, FIFO pointers and decode outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ir        <= NOP_WORD;
      pc_out    <= '0;
      ir_valid  <= 1'b0;
    end else begin
      fetch_pc  <= fetch_pc_next;
      imem_req  <= req_next;
      imem_addr <= fetch_pc_next;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end

      if (redirect) begin
        ir       <= NOP_WORD;
        ir_valid <= 1'b0;
      end else if (!stall_if) begin
        if (count != '0) begin
          ir       <= fifo_ir[rd_ptr];
          pc_out   <= fifo_pc[rd_ptr];
          ir_valid <= 1'b1;
        end else begin
          // Bubble: pc_out keeps the last real PC
          ir       <= NOP_WORD;
          ir_valid <= 1'b0;
        end
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc[wr_ptr] <= fetch_pc;
      fifo_ir[wr_ptr] <= imem_data;
    end
  end

endmodule
